// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and widths
// Holds the memory-stage FSM encoding, ALU op codes and datapath widths.
package pipe_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {IDLE, ACCESS} mem_state_t;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_LUI  = 4'b1010,
    ALU_JAL  = 4'b1011
  } alu_op_t;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles spent in a memory access
// Ports: clr zeroes the count, en advances it, expired is high at TIMEOUT-1.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  assign expired = cnt_q == 8'(TIMEOUT - 1);
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline memory stage with req/ack data port and write-back register
// Ports: in_* from EX, stall to IF/ID/EX, dmem_* to data memory,
// wb_* registered write-back bundle, misalign_err/bus_err one-cycle error pulses.
module mem_access
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_reg_write,
  input  logic [XLEN-1:0]       in_result,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  misalign_err,
  output logic                  bus_err
);
  mem_state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, rwe_q, rwe_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, mis_q, mis_d, bus_q, bus_d;
  logic idle, mem_op, aligned, expired;
  assign idle = state_q == IDLE;
  assign mem_op = in_valid && (in_mem_read || in_mem_write);
  assign aligned = in_result[1:0] == 2'b00;
  // Gated by rst so the upstream hold releases the moment reset hits, even
  // while EX still presents a memory op.
  assign stall = !rst && (idle ? mem_op && aligned : !dmem_ack && !expired);
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .clr(idle), .en(!idle), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    rwe_d = rwe_q;
    wb_valid_d = 1'b0;
    wb_we_d = wb_we_q;
    wb_rd_d = wb_rd_q;
    wb_data_d = wb_data_q;
    mis_d = 1'b0;
    bus_d = 1'b0;
    if (idle) begin
      if (!mem_op) begin
        wb_valid_d = in_valid;
        wb_we_d = in_reg_write && in_rd != '0;
        wb_rd_d = in_rd;
        wb_data_d = in_result;
      end else if (!aligned) begin
        mis_d = 1'b1;
      end else begin
        state_d = ACCESS;
        req_d = 1'b1;
        we_d = in_mem_write;
        addr_d = {in_result[XLEN-1:2], 2'b00};
        wdata_d = in_store_data;
        rd_d = in_rd;
        rwe_d = in_mem_read && in_reg_write && in_rd != '0;
      end
    end else if (dmem_ack) begin
      state_d = IDLE;
      req_d = 1'b0;
      wb_valid_d = 1'b1;
      wb_we_d = rwe_q;
      wb_rd_d = rd_q;
      wb_data_d = dmem_rdata;
    end else if (expired) begin
      state_d = IDLE;
      req_d = 1'b0;
      bus_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      rwe_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      mis_q <= 1'b0;
      bus_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      rwe_q <= rwe_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q <= wb_we_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mis_q <= mis_d;
      bus_q <= bus_d;
    end
  end
  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_we = wb_we_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign misalign_err = mis_q;
  assign bus_err = bus_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access
module tb_mem_access;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [31:0] in_result, in_store_data;
  logic [4:0] in_rd;
  logic stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic wb_valid, wb_we, misalign_err, bus_err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_result(in_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );
  always @(posedge clk) assert (!(in_mem_read && in_mem_write));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
    in_result = 0; in_store_data = 0; in_rd = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask
  // kind: 0 = ALU op, 1 = lw, 2 = sw. lat = ACCESS cycle that acks (>TIMEOUT: never).
  // Called and returning just after a falling edge; outputs are checked there.
  task automatic run_instr(input int kind, input bit valid, input logic [31:0] res,
                           input logic [31:0] sd, input logic [4:0] rd, input bit rw,
                           input int lat, input logic [31:0] rdata);
    bit mem, ok, acked;
    mem = valid && kind != 0;
    ok = res[1:0] == 2'b00;
    acked = 0;
    in_valid = valid; in_mem_read = kind == 1; in_mem_write = kind == 2;
    in_reg_write = rw; in_result = res; in_store_data = sd; in_rd = rd;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    #1 check("stall_issue", 32'(stall), 32'(mem && ok));
    if (!mem) begin
      @(negedge clk);
      check("alu_wb_valid", 32'(wb_valid), 32'(valid));
      if (valid) begin
        check("alu_wb_we", 32'(wb_we), 32'(rw && rd != 0));
        check("alu_wb_rd", 32'(wb_rd), 32'(rd));
        check("alu_wb_data", wb_data, res);
      end
      check("alu_req", 32'(dmem_req), 0);
      check("alu_errs", {misalign_err, bus_err}, 0);
      return;
    end
    if (!ok) begin
      @(negedge clk);
      check("mis_err", 32'(misalign_err), 1);
      check("mis_wb_valid", 32'(wb_valid), 0);
      check("mis_req", 32'(dmem_req), 0);
      check("mis_bus_err", 32'(bus_err), 0);
      return;
    end
    for (int i = 1; i <= TIMEOUT && !acked; i++) begin
      @(negedge clk);
      check("acc_req", 32'(dmem_req), 1);
      check("acc_addr", dmem_addr, res);
      check("acc_we", 32'(dmem_we), 32'(kind == 2));
      check("acc_wdata", dmem_wdata, sd);
      check("acc_quiet", {wb_valid, misalign_err, bus_err}, 0);
      in_valid = 1'($urandom); in_mem_read = 1'($urandom);
      in_mem_write = in_mem_read ? 1'b0 : 1'($urandom);
      in_reg_write = 1'($urandom); in_result = $urandom; in_store_data = $urandom;
      in_rd = 5'($urandom);
      acked = i == lat;
      dmem_ack = acked;
      dmem_rdata = acked ? rdata : $urandom;
      #1 check("stall_access", 32'(stall), 32'(!acked && i < TIMEOUT));
    end
    @(negedge clk);
    dmem_ack = 0;
    check("done_req", 32'(dmem_req), 0);
    check("done_wb_valid", 32'(wb_valid), 32'(acked));
    check("done_bus_err", 32'(bus_err), 32'(!acked));
    check("done_mis", 32'(misalign_err), 0);
    if (acked) begin
      check("done_wb_we", 32'(wb_we), 32'(kind == 1 && rw && rd != 0));
      check("done_wb_rd", 32'(wb_rd), 32'(rd));
      if (kind == 1) check("done_wb_data", wb_data, rdata);
    end
  endtask
  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_outs", {stall, dmem_req, dmem_we, wb_valid, wb_we, misalign_err, bus_err}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wb", {wb_data[26:0], wb_rd}, 0);
    rst = 0;
    @(negedge clk);
    run_instr(0, 1, 32'h10, 0, 5, 1, 1, 0);
    run_instr(1, 1, 32'h100, 0, 9, 1, 1, 32'hDEADBEEF);
    run_instr(2, 1, 32'h204, 32'h12345678, 0, 0, 3, 0);
    run_instr(1, 1, 32'h102, 0, 4, 1, 1, 0);
    run_instr(1, 1, 32'h400, 0, 6, 1, 99, 0);
    run_instr(1, 1, 32'h404, 0, 6, 1, TIMEOUT, 32'hCAFEF00D);
    run_instr(0, 0, 32'h55, 0, 3, 1, 1, 0);
    // reset two cycles into an access
    in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_reg_write = 1;
    in_result = 32'h300; in_rd = 7; dmem_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1 check("rst_mid_req", 32'(dmem_req), 0);
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_outs", {dmem_we, wb_valid, wb_we, misalign_err, bus_err}, 0);
    check("rst_mid_addr", dmem_addr, 0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(negedge clk);
    check("post_rst", {dmem_req, wb_valid, misalign_err, bus_err}, 0);
    run_instr(1, 1, 32'h500, 0, 0, 1, 2, 32'h11112222);
    for (int n = 0; n < 200; n++) begin
      int kind, lat;
      logic [31:0] res;
      kind = $urandom_range(0, 2);
      res = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT + 4) : $urandom_range(1, 3);
      run_instr(kind, $urandom_range(0, 7) != 0, res, $urandom, 5'($urandom),
                1'($urandom), lat, $urandom);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the execute ALU. It takes the ALU result (effective address for lw/sw, data for all other ops), performs word loads/stores over a request/acknowledge data-memory port, stalls upstream while an access is outstanding, and registers the write-back bundle for the WB stage. Misaligned addresses and unresponsive memory are flagged rather than hanging the pipeline.

## Interface
- TIMEOUT, 16: cycles in ACCESS without ack before abort; legal range 2..255.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX output holds a real instruction
- in_mem_read  in  1  instruction is lw
- in_mem_write  in  1  instruction is sw
- in_reg_write  in  1  instruction writes rd
- in_result  in  32  ALU result: address for lw/sw, value otherwise (jal link address included)
- in_store_data  in  32  rs2 value for sw
- in_rd  in  5  destination register
- stall  out  1  hold IF/ID/EX registers this cycle (combinational)
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = store, registered
- dmem_addr  out  32  word address (bits [1:0] always 0), registered
- dmem_wdata  out  32  store data, registered
- dmem_ack  in  1  memory done this cycle; may be asserted combinationally in the first req cycle
- dmem_rdata  in  32  load data, valid when dmem_ack
- wb_valid  out  1  write-back bundle valid, one-cycle pulse per instruction
- wb_we  out  1  register-file write enable (in_reg_write and rd != 0)
- wb_rd  out  5  destination register
- wb_data  out  32  value to write
- misalign_err  out  1  one-cycle pulse: lw/sw with address[1:0] != 0
- bus_err  out  1  one-cycle pulse: access aborted by timeout

## Operation
- mem_op = in_valid and (in_mem_read or in_mem_write); in_mem_read and in_mem_write never both set (bench asserts).
- FSM states: IDLE, ACCESS.
- IDLE, not mem_op: at edge wb_valid<=in_valid, wb_we<=in_reg_write and in_rd!=0, wb_rd<=in_rd, wb_data<=in_result. No stall.
- IDLE, mem_op, in_result[1:0]!=0: no access, no stall; at edge misalign_err<=1, wb_valid<=0.
- IDLE, mem_op, aligned: stall=1; at edge latch dmem_addr, dmem_wdata, dmem_we=in_mem_write, rd/write flags; dmem_req<=1; counter<=0; go ACCESS.
- ACCESS: inputs ignored; req/addr/we/wdata stable. stall = not dmem_ack and not timeout.
- ACCESS with dmem_ack: at edge dmem_req<=0, wb_valid<=1, wb_data<=dmem_rdata for load (store: wb_we<=0, wb_data don't-care), go IDLE.
- Timeout = counter == TIMEOUT-1 and no ack: stall=0; at edge dmem_req<=0, bus_err<=1, wb_valid<=0, go IDLE. Ack in same cycle as timeout wins (normal completion).
- dmem_ack in IDLE ignored.
- Load to x0: access performed, wb_we=0.

## Timing
- Reset values: state IDLE, dmem_req/dmem_we/wb_valid/wb_we/misalign_err/bus_err 0, dmem_addr/dmem_wdata/wb_rd/wb_data 0, counter 0.
- Non-memory op: presented cycle N, wb bundle valid cycle N+1.
- Memory op presented cycle N: stall high N; req high from N+1; ack in cycle N+k (k>=1) -> stall low in N+k, wb_valid in N+k+1. Minimum one stall cycle.
- Upstream advances on the edge ending the ack cycle; next instruction seen by this stage in N+k+1.
- Reset mid-access: req drops immediately (async), no wb_valid, no error pulse.
- wb_valid, misalign_err, bus_err each high exactly one cycle per event; never simultaneously.

## Structure
- Shared package pipe_pkg: FSM state encoding, ALU op codes (add 4'b0000 … jal 4'b1011), XLEN=32, REG_ADDR_W=5.
- One sub-module: mem_watchdog (counter with clear, enable, and expired output at TIMEOUT-1).

## Test plan
- addi result 0x0000_0010, rd=5, reg_write -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, stall never high.
- lw addr 0x100, memory acks on first req cycle with 0xDEADBEEF -> stall 1 cycle, dmem_req 1 cycle, wb_data=0xDEADBEEF, wb_we=1.
- sw addr 0x204 data 0x1234_5678, ack after 3 cycles -> dmem_we=1, addr/wdata stable 3 cycles, stall 3 cycles, wb_valid=1 with wb_we=0.
- lw addr 0x102 -> misalign_err pulse, dmem_req stays 0, wb_valid=0, no stall.
- lw with no ack, TIMEOUT=16 -> req high 16 cycles, bus_err pulse, stall released; repeat with ack in cycle 16 -> normal completion, no bus_err.
- rst asserted 2 cycles into an access -> dmem_req and stall fall same cycle, all outputs at reset values; lw rd=0 -> access done, wb_we=0.
